fir_addr_seq: RTL and testbench
===============================

# fir_addr_seq

Parametrised address and strobe sequencer for the DSP58 FIR datapath. It walks the coefficient memory and the sample memory for every output sample and every channel, and issues one read per cycle. It marks the first and last tap of each accumulation and delays the result strobe so it lines up with the DSP58 pipeline output. It sits between the coefficient/sample memories and the DSP58 MAC, and replaces the fixed single-channel address counter with start/busy/done control, stall support and multi-channel sequencing.

## Interface
- H_ADDR_WIDTH, 4: coefficient address width; TAPS = 1<<H_ADDR_WIDTH.
- X_ADDR_WIDTH, 6: sample address width; X_DEPTH = 1<<X_ADDR_WIDTH; must satisfy X_DEPTH ≥ TAPS.
- NUM_CH, 1: channels, each with its own sample bank sharing one x_addr; CH_WIDTH = max(1, clog2(NUM_CH)).
- PIPE_DELAY, 4: DSP58 latency in cycles from read issue to accumulator output; must be ≥ 1.
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- stall  in  1  while high, address generation freezes.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the job completes.
- rd_en  out  1  memory read enable for the current address.
- h_addr  out  H_ADDR_WIDTH  coefficient address.
- x_addr  out  X_ADDR_WIDTH  primary sample address.
- x_addr_b  out  X_ADDR_WIDTH  mirrored sample address (symmetric mode only; otherwise 0).
- ch_sel  out  CH_WIDTH  sample-bank / accumulator select.
- acc_first  out  1  high with tap 0 issue; the MAC loads the product instead of accumulating it.
- y_valid  out  1  accumulator output valid; PIPE_DELAY cycles after the last-tap issue.
- y_ch  out  CH_WIDTH  channel of the y_valid result.
- y_index  out  X_ADDR_WIDTH  output sample index n of the y_valid result.

## Operation
- N_OUT = X_DEPTH − TAPS + 1. The default is 49.
- Loop order, innermost first:
  - tap k, from 0 to K_LAST;
  - channel c, from 0 to NUM_CH−1;
  - output n, from 0 to N_OUT−1.
- Addresses per issue:
  - h_addr = k;
  - x_addr = n + TAPS − 1 − k;
  - ch_sel = c.
- FSM states and transitions:
  - IDLE: leaves to RUN when start is high.
  - RUN: issues one address per non-stalled cycle; leaves to DRAIN after the final issue (n = N_OUT−1, c = NUM_CH−1, k = K_LAST).
  - DRAIN: waits PIPE_DELAY cycles, then returns to IDLE with done pulsed.
- All outputs are registered.
- rd_en = 1 in RUN when stall is low, and 0 otherwise.
- When stall is high:
  - k, c and n hold;
  - rd_en and acc_first are driven 0;
  - the marker pipeline keeps shifting, so stalls appear as bubbles downstream.
- acc_first = rd_en & (k == 0).
- Last-tap marker (rd_en & k == K_LAST), together with c and n, enters a PIPE_DELAY-stage shift register. Its outputs are y_valid, y_ch and y_index.
- Counters use wrap-free compare-and-clear. x_addr is computed at X_ADDR_WIDTH+1 bits and never exceeds X_DEPTH−1.
- Boundary cases:
  - start while busy is ignored;
  - stall in IDLE or DRAIN has no effect;
  - rst_n low at any point (mid-RUN or mid-DRAIN) returns the block to IDLE and clears all counters and the marker pipeline; no y_valid is produced for the aborted job.
- Reset values: busy=0, done=0, rd_en=0, h_addr=0, x_addr=TAPS−1, x_addr_b=0, ch_sel=0, acc_first=0, y_valid=0, y_ch=0, y_index=0.

## Timing
- start sampled high in IDLE at edge T:
  - busy=1 and the first issue (k=0, n=0, c=0) are visible after edge T+1.
- Issue cycles: N_OUT·NUM_CH·(K_LAST+1) plus the number of stall cycles.
- y_valid for a tuple rises exactly PIPE_DELAY cycles after that tuple's last-tap issue cycle.
- The last y_valid coincides with the final DRAIN cycle.
- done pulses for one cycle on the cycle after the last y_valid, together with busy=0.
- A new start is accepted in the cycle done is high or later.

## Configuration
- FIR_SEQ_SYMM_EN defined (symmetric coefficients; TAPS must be even):
  - K_LAST = TAPS/2 − 1;
  - x_addr_b = n + k, the mirrored sample for pre-adder use;
  - per-output cost is TAPS/2 cycles.
- FIR_SEQ_SYMM_EN undefined:
  - K_LAST = TAPS − 1;
  - x_addr_b is held at 0.

## Structure
- Package fir_seq_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - derived constants TAPS, X_DEPTH, N_OUT and CH_WIDTH;
  - a helper function computing K_LAST.
- Sub-module fir_strobe_delay: a parametrised PIPE_DELAY-deep shift register carrying {valid, ch, index}, with async clear.

## Test plan
- Defaults, NUM_CH=1, start pulse, no stall:
  - first three issues are (h,x) = (0,15), (1,14), (2,13);
  - issue 16 is (0,16);
  - 784 issues in total;
  - 49 y_valid pulses with y_index 0..48;
  - done one cycle after the last y_valid.
- NUM_CH=2:
  - ch_sel is 0 for 16 issues, then 1 for 16 issues, with identical x_addr sequences;
  - y_ch alternates 0,1;
  - 98 y_valid pulses.
- Stall held 5 cycles mid-tap (k=7):
  - rd_en=0 and addresses frozen for 5 cycles;
  - resumes at k=7;
  - total busy time extends by exactly 5 cycles.
- rst_n low during RUN at n=10:
  - all outputs take reset values asynchronously;
  - no further y_valid;
  - a fresh start restarts at n=0.
- start asserted while busy: ignored; the sequence and done timing are unchanged.
- FIR_SEQ_SYMM_EN defined:
  - per output, k runs 0..7;
  - at n=0, k=0: x_addr=15, x_addr_b=0;
  - 392 issues in total.

Source files
------------

// File: rtl/fir_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_seq_pkg: shared types, default geometry and sizing helpers for the FIR |
// | address sequencer. FIR_SEQ_SYMM_EN selects symmetric mode.  Rev 1.0        |
// +----------------------------------------------------------------------------+
package fir_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    function automatic int taps_f(input int h_aw);
        return 1 << h_aw;
    endfunction

    function automatic int x_depth_f(input int x_aw);
        return 1 << x_aw;
    endfunction

    function automatic int n_out_f(input int h_aw, input int x_aw);
        return x_depth_f(x_aw) - taps_f(h_aw) + 1;
    endfunction

    function automatic int ch_width_f(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    // Symmetric filters fold the coefficient set, so only half the taps are walked.
    function automatic int k_last_f(input int h_aw);
`ifdef FIR_SEQ_SYMM_EN
        return taps_f(h_aw) / 2 - 1;
`else
        return taps_f(h_aw) - 1;
`endif
    endfunction

    localparam int DEF_H_ADDR_WIDTH = 4;
    localparam int DEF_X_ADDR_WIDTH = 6;
    localparam int TAPS     = taps_f(DEF_H_ADDR_WIDTH);
    localparam int X_DEPTH  = x_depth_f(DEF_X_ADDR_WIDTH);
    localparam int N_OUT    = n_out_f(DEF_H_ADDR_WIDTH, DEF_X_ADDR_WIDTH);
    localparam int CH_WIDTH = ch_width_f(1);

endpackage
`default_nettype wire

// File: rtl/fir_strobe_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_strobe_delay: DEPTH-stage shift register carrying {valid, ch, index}   |
// | with asynchronous clear.  Rev 1.0                                          |
// +----------------------------------------------------------------------------+
module fir_strobe_delay #(
    parameter int DEPTH = 4,
    parameter int CH_W  = 1,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [CH_W-1:0]  ch_i,
    input  logic [IDX_W-1:0] index_i,
    output logic             valid_o,
    output logic [CH_W-1:0]  ch_o,
    output logic [IDX_W-1:0] index_o
);

    logic [DEPTH-1:0] valid_q;
    logic [CH_W-1:0]  ch_q  [DEPTH];
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ch_q[i]  <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            ch_q[0]    <= ch_i;
            idx_q[0]   <= index_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                ch_q[i]    <= ch_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign ch_o    = ch_q[DEPTH-1];
    assign index_o = idx_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fir_addr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_addr_seq: coefficient/sample address and strobe sequencer for the      |
// | DSP58 FIR MAC; FIR_SEQ_SYMM_EN enables symmetric (pre-adder) mode. Rev 1.0 |
// +----------------------------------------------------------------------------+
module fir_addr_seq
    import fir_seq_pkg::*;
#(
    parameter  int H_ADDR_WIDTH = DEF_H_ADDR_WIDTH,
    parameter  int X_ADDR_WIDTH = DEF_X_ADDR_WIDTH,
    parameter  int NUM_CH       = 1,
    parameter  int PIPE_DELAY   = 4,
    localparam int CH_WIDTH     = ch_width_f(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    stall_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    rd_en_o,
    output logic [H_ADDR_WIDTH-1:0] h_addr_o,
    output logic [X_ADDR_WIDTH-1:0] x_addr_o,
    output logic [X_ADDR_WIDTH-1:0] x_addr_b_o,
    output logic [CH_WIDTH-1:0]     ch_sel_o,
    output logic                    acc_first_o,
    output logic                    y_valid_o,
    output logic [CH_WIDTH-1:0]     y_ch_o,
    output logic [X_ADDR_WIDTH-1:0] y_index_o
);

    localparam int TAPS    = taps_f(H_ADDR_WIDTH);
    localparam int X_DEPTH = x_depth_f(X_ADDR_WIDTH);
    localparam int N_OUT   = X_DEPTH - TAPS + 1;
    localparam int K_LAST  = k_last_f(H_ADDR_WIDTH);
    localparam int X1W     = X_ADDR_WIDTH + 1;
    localparam int DRAIN_W = $clog2(PIPE_DELAY + 1);

    localparam logic [H_ADDR_WIDTH-1:0] K_LAST_V   = H_ADDR_WIDTH'(K_LAST);
    localparam logic [CH_WIDTH-1:0]     C_LAST_V   = CH_WIDTH'(NUM_CH - 1);
    localparam logic [X_ADDR_WIDTH-1:0] N_LAST_V   = X_ADDR_WIDTH'(N_OUT - 1);
    localparam logic [X_ADDR_WIDTH-1:0] X_RESET_V  = X_ADDR_WIDTH'(TAPS - 1);
    localparam logic [DRAIN_W-1:0]      DRAIN_LAST = DRAIN_W'(PIPE_DELAY);

    seq_state_e              state_q;
    logic [H_ADDR_WIDTH-1:0] k_q, k_d;
    logic [CH_WIDTH-1:0]     c_q, c_d;
    logic [X_ADDR_WIDTH-1:0] n_q, n_d;
    logic [DRAIN_W-1:0]      drain_q;

    logic                    busy_q, done_q, rd_en_q, acc_first_q, last_q;
    logic [H_ADDR_WIDTH-1:0] h_addr_q;
    logic [X_ADDR_WIDTH-1:0] x_addr_q, x_addr_b_q, idx_q;
    logic [CH_WIDTH-1:0]     ch_sel_q;

    logic                    k_wrap, c_wrap, n_wrap, final_issue;
    logic [X1W-1:0]          x_full;
    logic [X_ADDR_WIDTH-1:0] x_addr_d, x_addr_b_d;

    // Compare-and-clear counters: k innermost, then channel, then output index.
    always_comb begin
        k_wrap      = (k_q == K_LAST_V);
        c_wrap      = (c_q == C_LAST_V);
        n_wrap      = (n_q == N_LAST_V);
        final_issue = k_wrap & c_wrap & n_wrap;
        k_d = k_wrap ? '0 : k_q + H_ADDR_WIDTH'(1);
        c_d = c_q;
        n_d = n_q;
        if (k_wrap) begin
            c_d = c_wrap ? '0 : c_q + CH_WIDTH'(1);
            if (c_wrap) begin
                n_d = n_wrap ? '0 : n_q + X_ADDR_WIDTH'(1);
            end
        end
    end

    // One guard bit keeps the subtraction exact; the result never exceeds X_DEPTH-1.
    assign x_full   = X1W'(n_q) + X1W'(TAPS - 1) - X1W'(k_q);
    assign x_addr_d = X_ADDR_WIDTH'(x_full);

`ifdef FIR_SEQ_SYMM_EN
    logic [X1W-1:0] x_b_full;
    assign x_b_full   = X1W'(n_q) + X1W'(k_q);
    assign x_addr_b_d = X_ADDR_WIDTH'(x_b_full);
`else
    assign x_addr_b_d = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            c_q         <= '0;
            n_q         <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            acc_first_q <= 1'b0;
            last_q      <= 1'b0;
            h_addr_q    <= '0;
            x_addr_q    <= X_RESET_V;
            x_addr_b_q  <= '0;
            ch_sel_q    <= '0;
            idx_q       <= '0;
        end else begin
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            acc_first_q <= 1'b0;
            last_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        c_q     <= '0;
                        n_q     <= '0;
                    end
                end
                ST_RUN: begin
                    // A stalled cycle issues nothing; addresses hold their last issued values.
                    if (!stall_i) begin
                        rd_en_q     <= 1'b1;
                        acc_first_q <= (k_q == '0);
                        last_q      <= k_wrap;
                        h_addr_q    <= k_q;
                        x_addr_q    <= x_addr_d;
                        x_addr_b_q  <= x_addr_b_d;
                        ch_sel_q    <= c_q;
                        idx_q       <= n_q;
                        k_q         <= k_d;
                        c_q         <= c_d;
                        n_q         <= n_d;
                        if (final_issue) begin
                            state_q <= ST_DRAIN;
                            drain_q <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DRAIN_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    fir_strobe_delay #(
        .DEPTH (PIPE_DELAY),
        .CH_W  (CH_WIDTH),
        .IDX_W (X_ADDR_WIDTH)
    ) u_strobe_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (last_q),
        .ch_i    (ch_sel_q),
        .index_i (idx_q),
        .valid_o (y_valid_o),
        .ch_o    (y_ch_o),
        .index_o (y_index_o)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign h_addr_o    = h_addr_q;
    assign x_addr_o    = x_addr_q;
    assign x_addr_b_o  = x_addr_b_q;
    assign ch_sel_o    = ch_sel_q;
    assign acc_first_o = acc_first_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_addr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_addr_seq: directed self-checking bench for fir_addr_seq (1 and 2    |
// | channel instances; honours FIR_SEQ_SYMM_EN).  Rev 1.0                      |
// +----------------------------------------------------------------------------+
module tb_fir_addr_seq;

    localparam int TAPS  = 16;
    localparam int P     = 4;
    localparam int N_OUT = 49;
`ifdef FIR_SEQ_SYMM_EN
    localparam int KL    = 7;
`else
    localparam int KL    = 15;
`endif
    localparam int ISS1  = N_OUT * (KL + 1);

    logic clk = 1'b0;
    logic rst_n, start, stall, sel;

    logic       b1, d1, r1, af1, yv1, ch1, ych1;
    logic [3:0] h1;
    logic [5:0] x1, xb1, yi1;
    logic       b2, d2, r2, af2, yv2, ch2, ych2;
    logic [3:0] h2;
    logic [5:0] x2, xb2, yi2;

    always #5 clk = ~clk;

    fir_addr_seq #(.H_ADDR_WIDTH(4), .X_ADDR_WIDTH(6), .NUM_CH(1), .PIPE_DELAY(P)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start & ~sel), .stall_i(stall & ~sel),
        .busy_o(b1), .done_o(d1), .rd_en_o(r1), .h_addr_o(h1), .x_addr_o(x1),
        .x_addr_b_o(xb1), .ch_sel_o(ch1), .acc_first_o(af1), .y_valid_o(yv1),
        .y_ch_o(ych1), .y_index_o(yi1)
    );

    fir_addr_seq #(.H_ADDR_WIDTH(4), .X_ADDR_WIDTH(6), .NUM_CH(2), .PIPE_DELAY(P)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start & sel), .stall_i(stall & sel),
        .busy_o(b2), .done_o(d2), .rd_en_o(r2), .h_addr_o(h2), .x_addr_o(x2),
        .x_addr_b_o(xb2), .ch_sel_o(ch2), .acc_first_o(af2), .y_valid_o(yv2),
        .y_ch_o(ych2), .y_index_o(yi2)
    );

    logic       m_busy, m_done, m_rd, m_af, m_yv, m_ch, m_ych;
    logic [3:0] m_h;
    logic [5:0] m_x, m_xb, m_yi;
    assign m_busy = sel ? b2   : b1;
    assign m_done = sel ? d2   : d1;
    assign m_rd   = sel ? r2   : r1;
    assign m_af   = sel ? af2  : af1;
    assign m_yv   = sel ? yv2  : yv1;
    assign m_ch   = sel ? ch2  : ch1;
    assign m_ych  = sel ? ych2 : ych1;
    assign m_h    = sel ? h2   : h1;
    assign m_x    = sel ? x2   : x1;
    assign m_xb   = sel ? xb2  : xb1;
    assign m_yi   = sel ? yi2  : yi1;

    int n_checks, n_pass;
    int r_issues, r_busy, r_yv, r_seq_err, r_y_err, r_stall_err, r_done_err;
    int r_last_idx, r_fin, r_aborted;
    int f_h [0:31];
    int f_x [0:31];
    int f_xb[0:31];
    int f_ch[0:31];
    int y_ch_first[0:1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_reset_state(input string pfx);
        check_val({pfx, "_busy"},      32'(m_busy), 0);
        check_val({pfx, "_done"},      32'(m_done), 0);
        check_val({pfx, "_rd_en"},     32'(m_rd),   0);
        check_val({pfx, "_h_addr"},    32'(m_h),    0);
        check_val({pfx, "_x_addr"},    32'(m_x),    15);
        check_val({pfx, "_x_addr_b"},  32'(m_xb),   0);
        check_val({pfx, "_ch_sel"},    32'(m_ch),   0);
        check_val({pfx, "_acc_first"}, 32'(m_af),   0);
        check_val({pfx, "_y_valid"},   32'(m_yv),   0);
        check_val({pfx, "_y_ch"},      32'(m_ych),  0);
        check_val({pfx, "_y_index"},   32'(m_yi),   0);
    endtask

    task automatic run_job(input bit use2, input int stall_at, input int abort_n,
                           input bit poke, input int exp_total);
        int ek, ec, en, cyc, nch, stall_left, last_y_cyc, post_yv, exp_xb;
        int q_t[$];
        int q_c[$];
        int q_n[$];
        bit stall_used, poked_run, poked_drain, do_abort;
        sel = use2;
        nch = use2 ? 2 : 1;
        r_issues = 0; r_busy = 0; r_yv = 0; r_seq_err = 0; r_y_err = 0;
        r_stall_err = 0; r_done_err = 0; r_last_idx = -1; r_fin = 0; r_aborted = 0;
        ek = 0; ec = 0; en = 0; cyc = 0; stall_left = 0; last_y_cyc = -100;
        stall_used = 0; poked_run = 0; poked_drain = 0; do_abort = 0;
        y_ch_first[0] = -1; y_ch_first[1] = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_val("busy_after_start", 32'(m_busy), 1);
        check_val("rd_en_before_first_issue", 32'(m_rd), 0);
        r_busy = 1;
        while (r_fin == 0 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (m_busy) r_busy++;
            if (m_rd) begin
                exp_xb = 0;
`ifdef FIR_SEQ_SYMM_EN
                exp_xb = en + ek;
`endif
                if (r_issues < 32) begin
                    f_h[r_issues] = int'(m_h);  f_x[r_issues]  = int'(m_x);
                    f_xb[r_issues] = int'(m_xb); f_ch[r_issues] = int'(m_ch);
                end
                if (int'(m_h) != ek || int'(m_x) != en + TAPS - 1 - ek || int'(m_ch) != ec ||
                    m_af != (ek == 0) || int'(m_xb) != exp_xb)
                    r_seq_err++;
                if (abort_n >= 0 && en == abort_n && ek == 1) do_abort = 1;
                if (ek == KL) begin
                    q_t.push_back(cyc + P); q_c.push_back(ec); q_n.push_back(en);
                    ek = 0;
                    if (ec == nch - 1) begin ec = 0; en++; end else ec++;
                end else ek++;
                r_issues++;
            end else if (m_af) r_seq_err++;
            if (q_t.size() > 0 && q_t[0] == cyc) begin
                if (!m_yv || int'(m_ych) != q_c[0] || int'(m_yi) != q_n[0]) r_y_err++;
                last_y_cyc = cyc;
                void'(q_t.pop_front()); void'(q_c.pop_front()); void'(q_n.pop_front());
            end else if (m_yv) r_y_err++;
            if (m_yv) begin
                if (r_yv < 2) y_ch_first[r_yv] = int'(m_ych);
                r_last_idx = int'(m_yi);
                r_yv++;
            end
            if (m_done) begin
                if (cyc != last_y_cyc + 1 || m_busy) r_done_err++;
                r_fin = 1;
            end
            if (stall_left > 0) begin
                stall_left--;
                if (m_rd || int'(m_h) != stall_at - 1 || int'(m_x) != TAPS - stall_at) r_stall_err++;
                if (stall_left == 0) stall = 1'b0;
            end else if (stall_at >= 0 && !stall_used && r_issues == stall_at) begin
                stall = 1'b1; stall_left = 5; stall_used = 1;
            end else if (stall_at >= 0 && r_issues == exp_total) begin
                stall = 1'b1;
            end
            if (poke && !poked_run && r_issues == 100) begin
                start = 1'b1; poked_run = 1;
            end else if (poke && !poked_drain && r_issues == exp_total) begin
                start = 1'b1; poked_drain = 1;
            end
            if (do_abort) begin
                #2 rst_n = 1'b0;
                #1 chk_reset_state("abort");
                r_aborted = 1;
                r_fin = 1;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        check_val("job_finished", 32'(r_fin), 1);
        if (r_aborted != 0) begin
            @(posedge clk); #1 rst_n = 1'b1;
            post_yv = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (m_yv || m_busy) post_yv++;
            end
            check_val("abort_no_yvalid_or_busy", 32'(post_yv), 0);
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_state("rst");
        rst_n = 1'b1;

        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("idle_stall_rd_en", 32'(m_rd), 0);
        check_val("idle_stall_busy", 32'(m_busy), 0);
        stall = 1'b0;

        // Single channel, no stall, with stray start pulses in RUN and DRAIN.
        run_job(1'b0, -1, -1, 1'b1, ISS1);
        check_val("a_issues", 32'(r_issues), ISS1);
        check_val("a_seq_err", 32'(r_seq_err), 0);
        check_val("a_y_err", 32'(r_y_err), 0);
        check_val("a_y_count", 32'(r_yv), N_OUT);
        check_val("a_last_y_index", 32'(r_last_idx), 48);
        check_val("a_done_timing", 32'(r_done_err), 0);
        check_val("a_busy_cycles", 32'(r_busy), ISS1 + P + 1);
        check_val("a_issue0_h", 32'(f_h[0]), 0);
        check_val("a_issue0_x", 32'(f_x[0]), 15);
        check_val("a_issue0_xb", 32'(f_xb[0]), 0);
        check_val("a_issue1_h", 32'(f_h[1]), 1);
        check_val("a_issue1_x", 32'(f_x[1]), 14);
        check_val("a_issue2_h", 32'(f_h[2]), 2);
        check_val("a_issue2_x", 32'(f_x[2]), 13);
`ifdef FIR_SEQ_SYMM_EN
        check_val("a_issue1_xb", 32'(f_xb[1]), 1);
        check_val("a_issue8_h", 32'(f_h[8]), 0);
        check_val("a_issue8_x", 32'(f_x[8]), 16);
        check_val("a_issue8_xb", 32'(f_xb[8]), 1);
`else
        check_val("a_issue1_xb", 32'(f_xb[1]), 0);
        check_val("a_issue16_h", 32'(f_h[16]), 0);
        check_val("a_issue16_x", 32'(f_x[16]), 16);
`endif

        // Five-cycle stall before k=7, plus stall held through DRAIN.
        run_job(1'b0, 7, -1, 1'b0, ISS1);
        check_val("b_issues", 32'(r_issues), ISS1);
        check_val("b_stall_err", 32'(r_stall_err), 0);
        check_val("b_seq_err", 32'(r_seq_err), 0);
        check_val("b_y_err", 32'(r_y_err), 0);
        check_val("b_y_count", 32'(r_yv), N_OUT);
        check_val("b_done_timing", 32'(r_done_err), 0);
        check_val("b_busy_cycles", 32'(r_busy), ISS1 + P + 1 + 5);

        // Two channels.
        run_job(1'b1, -1, -1, 1'b0, 2 * ISS1);
        check_val("c_issues", 32'(r_issues), 2 * ISS1);
        check_val("c_seq_err", 32'(r_seq_err), 0);
        check_val("c_y_err", 32'(r_y_err), 0);
        check_val("c_y_count", 32'(r_yv), 2 * N_OUT);
        check_val("c_y_ch_first0", 32'(y_ch_first[0]), 0);
        check_val("c_y_ch_first1", 32'(y_ch_first[1]), 1);
        check_val("c_ch_before_switch", 32'(f_ch[KL]), 0);
        check_val("c_ch_after_switch", 32'(f_ch[KL + 1]), 1);
        check_val("c_x_after_switch", 32'(f_x[KL + 1]), 15);
        check_val("c_h_after_switch", 32'(f_h[KL + 1]), 0);
        check_val("c_done_timing", 32'(r_done_err), 0);
        check_val("c_busy_cycles", 32'(r_busy), 2 * ISS1 + P + 1);

        // Reset mid-RUN at n=10, then a fresh job.
        run_job(1'b0, -1, 10, 1'b0, ISS1);
        check_val("d_aborted", 32'(r_aborted), 1);
        check_val("d_seq_err", 32'(r_seq_err), 0);
        run_job(1'b0, -1, -1, 1'b0, ISS1);
        check_val("e_issue0_h", 32'(f_h[0]), 0);
        check_val("e_issue0_x", 32'(f_x[0]), 15);
        check_val("e_issues", 32'(r_issues), ISS1);
        check_val("e_seq_err", 32'(r_seq_err), 0);
        check_val("e_y_count", 32'(r_yv), N_OUT);
        check_val("e_y_err", 32'(r_y_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
